// File: rtl/riscv_mtimer_if.sv
// rtl/riscv_mtimer_if.sv - CPU data-bus port bundle for the machine timer
// Master is the core side; slave is the timer.
interface riscv_mtimer_if;
    logic        sel;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/riscv_mtimer.sv
// rtl/riscv_mtimer.sv - memory-mapped mtime/mtimecmp machine timer driving t_inter
// Optional feature: MTIMER_AUTORELOAD_EN adds PERIOD_LO/HI and CTRL.RELOAD.
module riscv_mtimer #(
    parameter int          DIV_W     = 8,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    riscv_mtimer_if.slave    bus,
    output logic             t_inter
);

    logic [63:0]      r_mtime;
    logic [63:0]      r_mtimecmp;
    logic             r_en;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_t_inter;
`ifdef MTIMER_AUTORELOAD_EN
    logic             r_reload;
    logic [63:0]      r_period;
`endif

    logic [2:0]  w_idx;
    logic        w_wr;
    logic        w_wr_mlo;
    logic        w_wr_mhi;
    logic        w_wr_clo;
    logic        w_wr_chi;
    logic        w_wr_ctrl;
    logic        w_tick;
    logic        w_hit;
    logic [31:0] w_ctrl;
    logic        w_unused_addr;

    assign w_idx         = bus.addr[4:2];
    assign w_unused_addr = &{1'b0, bus.addr[1:0]};
    assign w_wr          = bus.sel & bus.we;
    assign w_wr_mlo      = w_wr && (w_idx == 3'd0);
    assign w_wr_mhi      = w_wr && (w_idx == 3'd1);
    assign w_wr_clo      = w_wr && (w_idx == 3'd2);
    assign w_wr_chi      = w_wr && (w_idx == 3'd3);
    assign w_wr_ctrl     = w_wr && (w_idx == 3'd4);

    assign w_tick = r_en && (r_cnt == r_div);
    assign w_hit  = (r_mtime >= r_mtimecmp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en  <= 1'b0;
            r_div <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en  <= bus.wdata[0];
                r_div <= bus.wdata[8 +: DIV_W];
                r_cnt <= '0;
            end else if (!r_en || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

    // A bus write to either half beats the tick; the untouched half keeps its value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtime <= '0;
        end else if (w_wr_mlo) begin
            r_mtime[31:0] <= bus.wdata;
        end else if (w_wr_mhi) begin
            r_mtime[63:32] <= bus.wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtimecmp <= CMP_RESET;
        end else if (w_wr_clo) begin
            r_mtimecmp[31:0] <= bus.wdata;
        end else if (w_wr_chi) begin
            r_mtimecmp[63:32] <= bus.wdata;
`ifdef MTIMER_AUTORELOAD_EN
        end else if (r_en && r_reload && w_hit) begin
            r_mtimecmp <= r_mtimecmp + r_period;
`endif
        end
    end

`ifdef MTIMER_AUTORELOAD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reload <= 1'b0;
            r_period <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_reload <= bus.wdata[1];
            end
            if (w_wr && (w_idx == 3'd5)) begin
                r_period[31:0] <= bus.wdata;
            end
            if (w_wr && (w_idx == 3'd6)) begin
                r_period[63:32] <= bus.wdata;
            end
        end
    end
`endif

    // With reload on, the compare moves past mtime on the hit edge, so the level becomes a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_t_inter <= 1'b0;
        end else begin
            r_t_inter <= r_en & w_hit;
        end
    end

    assign t_inter = r_t_inter;

    always_comb begin
        w_ctrl              = '0;
        w_ctrl[0]           = r_en;
`ifdef MTIMER_AUTORELOAD_EN
        w_ctrl[1]           = r_reload;
`endif
        w_ctrl[8 +: DIV_W]  = r_div;
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (w_idx)
                3'd0:    bus.rdata = r_mtime[31:0];
                3'd1:    bus.rdata = r_mtime[63:32];
                3'd2:    bus.rdata = r_mtimecmp[31:0];
                3'd3:    bus.rdata = r_mtimecmp[63:32];
                3'd4:    bus.rdata = w_ctrl;
`ifdef MTIMER_AUTORELOAD_EN
                3'd5:    bus.rdata = r_period[31:0];
                3'd6:    bus.rdata = r_period[63:32];
`endif
                default: bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mtimer.sv
// tb/tb_riscv_mtimer.sv - self-checking bench for riscv_mtimer
// Builds with or without MTIMER_AUTORELOAD_EN.
module tb_riscv_mtimer;

`ifdef MTIMER_AUTORELOAD_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic t_inter;
    int   total = 0;
    int   bad = 0;

    riscv_mtimer_if bus_if ();

    riscv_mtimer dut (
        .clk     (clk),
        .rst     (rst_n),
        .bus     (bus_if.slave),
        .t_inter (t_inter)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    // Reference model state: architectural registers plus enabled-cycle count since restart.
    logic [63:0] m_time, m_cmp, m_per;
    bit          m_en, m_rl, m_ti;
    int          m_div, m_run;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus_if.sel = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus_if.sel = 1'b0; bus_if.we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus_if.sel = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
        #1;
        d = bus_if.rdata;
        bus_if.sel = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] mrd(input logic [2:0] idx);
        logic [31:0] v;
        case (idx)
            3'd0: v = m_time[31:0];
            3'd1: v = m_time[63:32];
            3'd2: v = m_cmp[31:0];
            3'd3: v = m_cmp[63:32];
            3'd4: v = {16'h0, 8'(m_div), 6'h0, m_rl, m_en};
            3'd5: v = FEAT ? m_per[31:0] : 32'h0;
            3'd6: v = FEAT ? m_per[63:32] : 32'h0;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic mstep(input bit we, input logic [2:0] idx, input logic [31:0] d);
        bit tick, hit;
        tick = m_en && ((m_run % (m_div + 1)) == m_div);
        hit  = (m_time >= m_cmp);
        m_ti = m_en && hit;
        if (we && idx == 3'd0)      m_time = {m_time[63:32], d};
        else if (we && idx == 3'd1) m_time = {d, m_time[31:0]};
        else if (tick)              m_time = m_time + 64'd1;
        if (we && idx == 3'd2)      m_cmp = {m_cmp[63:32], d};
        else if (we && idx == 3'd3) m_cmp = {d, m_cmp[31:0]};
        else if (FEAT && m_en && m_rl && hit) m_cmp = m_cmp + m_per;
        if (FEAT && we && idx == 3'd5) m_per = {m_per[63:32], d};
        if (FEAT && we && idx == 3'd6) m_per = {d, m_per[31:0]};
        if (we && idx == 3'd4) begin
            m_en  = d[0];
            m_rl  = FEAT && d[1];
            m_div = int'(d[15:8]);
            m_run = 0;
        end else begin
            m_run = m_en ? m_run + 1 : 0;
        end
    endtask

    function automatic logic [31:0] gen(input logic [2:0] idx);
        logic [31:0] d;
        case (idx)
            3'd0: d = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : ($urandom % 64);
            3'd1: d = ($urandom % 6 == 0) ? $urandom : 32'h0;
            3'd2: d = $urandom % 96;
            3'd3: d = ($urandom % 8 == 0) ? 32'h1 : 32'h0;
            3'd4: begin
                d = ($urandom & 32'hFFFF_00FF) | (($urandom % 4) << 8);
                d[0] = ($urandom % 4 != 0);
            end
            3'd5: d = $urandom % 24;
            3'd6: d = 32'h0;
            default: d = $urandom;
        endcase
        return d;
    endfunction

    initial begin
        vec_t        tbl[16];
        logic [31:0] v, v2;
        bit          seen, found;
        int          pulses, wide;
        bit          prev;

        bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
        @(negedge clk);
        #1;
        chk("rdata_sel0_in_reset", bus_if.rdata, 0);
        chk("tinter_in_reset", t_inter, 0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = '{0, 5'h00, 32'h0, 32'h0};
        tbl[1]  = '{0, 5'h04, 32'h0, 32'h0};
        tbl[2]  = '{0, 5'h08, 32'h0, 32'hFFFF_FFFF};
        tbl[3]  = '{0, 5'h0C, 32'h0, 32'hFFFF_FFFF};
        tbl[4]  = '{0, 5'h10, 32'h0, 32'h0};
        tbl[5]  = '{0, 5'h14, 32'h0, 32'h0};
        tbl[6]  = '{0, 5'h18, 32'h0, 32'h0};
        tbl[7]  = '{0, 5'h1C, 32'h0, 32'h0};
        tbl[8]  = '{1, 5'h10, 32'hFFFF_FF0E, FEAT ? 32'h0000_FF02 : 32'h0000_FF00};
        tbl[9]  = '{1, 5'h00, 32'h1234_5678, 32'h1234_5678};
        tbl[10] = '{1, 5'h04, 32'h9ABC_DEF0, 32'h9ABC_DEF0};
        tbl[11] = '{1, 5'h08, 32'h0BAD_F00D, 32'h0BAD_F00D};
        tbl[12] = '{1, 5'h0C, 32'h0000_0001, 32'h0000_0001};
        tbl[13] = '{1, 5'h1C, 32'hDEAD_BEEF, 32'h0};
        tbl[14] = '{1, 5'h14, 32'h0000_0011, FEAT ? 32'h0000_0011 : 32'h0};
        tbl[15] = '{0, 5'h03, 32'h0, 32'h1234_5678};
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].we) wr(tbl[i].a, tbl[i].d);
            rd(tbl[i].a, v);
            chk($sformatf("vec%0d_addr%02h", i, tbl[i].a), v, tbl[i].exp);
        end

        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (t_inter) seen = 1'b1;
            cyc(1);
        end
        chk("tinter_quiet_1000", seen, 0);

        wr(5'h10, 32'h0000_0301);
        cyc(40);
        rd(5'h00, v);
        chk("prescale_div3_40cyc", v, 10);
        wr(5'h10, 32'h0000_0300);
        cyc(20);
        rd(5'h00, v);
        chk("prescale_hold_en0", v, 10);

        do_reset();
        wr(5'h0C, 32'h0);
        wr(5'h08, 32'd20);
        wr(5'h10, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rd(5'h00, v);
            if (v == 32'd20) begin
                chk("tinter_low_at_20", t_inter, 0);
                cyc(1);
                chk("tinter_rise_20", t_inter, 1);
                found = 1'b1;
                break;
            end
            cyc(1);
        end
        chk("reach_20_in_budget", found, 1);
        wr(5'h08, 32'd100);
        chk("tinter_hold_at_cmp_write", t_inter, 1);
        cyc(1);
        chk("tinter_fall_cmp100", t_inter, 0);

        wr(5'h08, 32'd0);
        cyc(1);
        chk("tinter_high_pre_reset", t_inter, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("tinter_async_drop", t_inter, 0);
        rd(5'h00, v);
        chk("mtime_async_clear", v, 0);
        @(negedge clk);
        rst_n = 1'b1;

        wr(5'h04, 32'h0);
        wr(5'h00, 32'hFFFF_FFFE);
        wr(5'h10, 32'h1);
        cyc(1);
        rd(5'h00, v);
        rd(5'h04, v2);
        chk("carry_pre_lo", v, 32'hFFFF_FFFF);
        chk("carry_pre_hi", v2, 0);
        cyc(1);
        rd(5'h00, v);
        rd(5'h04, v2);
        chk("carry_lo", v, 0);
        chk("carry_hi", v2, 1);
        wr(5'h10, 32'h0);
        wr(5'h04, 32'hFFFF_FFFF);
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h10, 32'h1);
        cyc(1);
        rd(5'h00, v);
        rd(5'h04, v2);
        chk("wrap_lo", v, 0);
        chk("wrap_hi", v2, 0);

        wr(5'h10, 32'h0);
        wr(5'h04, 32'd3);
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h10, 32'h1);
        wr(5'h00, 32'd5);
        rd(5'h00, v);
        rd(5'h04, v2);
        chk("wrprio_lo", v, 5);
        chk("wrprio_hi_held", v2, 3);

`ifdef MTIMER_AUTORELOAD_EN
        do_reset();
        wr(5'h0C, 32'h0);
        wr(5'h08, 32'd10);
        wr(5'h18, 32'h0);
        wr(5'h14, 32'd10);
        wr(5'h10, 32'h3);
        pulses = 0; wide = 0; prev = 1'b0; found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (t_inter && prev) wide++;
            if (t_inter && !prev) pulses++;
            prev = t_inter;
            if (pulses == 3) begin
                rd(5'h08, v);
                chk("reload_cmp_40", v, 40);
                cyc(1);
                chk("reload_pulse3_width", t_inter, 0);
                found = 1'b1;
                break;
            end
            cyc(1);
        end
        chk("reload_3_pulses", found, 1);
        chk("reload_pulse_width", wide, 0);
`endif

        do_reset();
        m_time = '0; m_cmp = '1; m_per = '0;
        m_en = 0; m_rl = 0; m_ti = 0; m_div = 0; m_run = 0;
        for (int i = 0; i < 2000; i++) begin
            int          r;
            logic [2:0]  idx;
            logic [31:0] d;
            r   = $urandom % 10;
            idx = 3'($urandom % 8);
            if (r < 2) begin
                d = gen(idx);
                bus_if.sel = 1'b1; bus_if.we = 1'b1;
                bus_if.addr = {idx, 2'b00}; bus_if.wdata = d;
                @(posedge clk);
                mstep(1'b1, idx, d);
            end else if (r == 2) begin
                bus_if.sel = 1'b0; bus_if.we = 1'b0;
                #1;
                chk("rand_sel0_rdata", bus_if.rdata, 0);
                @(posedge clk);
                mstep(1'b0, 3'd0, 32'h0);
            end else begin
                bus_if.sel = 1'b1; bus_if.we = 1'b0;
                bus_if.addr = {idx, 2'($urandom % 4)};
                #1;
                chk($sformatf("rand_rd_idx%0d_cyc%0d", idx, i), bus_if.rdata, mrd(idx));
                chk($sformatf("rand_tinter_cyc%0d", i), t_inter, m_ti);
                @(posedge clk);
                mstep(1'b0, 3'd0, 32'h0);
            end
            @(negedge clk);
            bus_if.sel = 1'b0; bus_if.we = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
